// File: rtl/eth_pkg.sv
// Shared Ethernet CRC-32 constants, RX FCS checker state type and the byte-wide CRC step used by both RX and TX.
package eth_pkg;

  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
  localparam int          FCS_LEN     = 4;

  typedef enum logic {IDLE, FRAME} rx_fcs_state_e;

  // Bits enter LSB first (wire order) into an MSB-out shift register.
  function automatic logic [31:0] crc32_byte_update(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_rx_holdback.sv
// Byte/valid shift register of DEPTH entries with flush; head_* is the entry that leaves on the next shift.
// DEPTH = 0 degenerates to a pass-through where the incoming byte is itself the head.
module eth_rx_holdback #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic              head_valid,
  output logic [DATA_W-1:0] head_data
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_ok;
      assign head_valid = 1'b1;
      assign head_data  = din;
      assign unused_ok  = ^{clk, reset, shift, flush};
    end else begin : g_shift
      logic [DATA_W-1:0] data_q [DEPTH];
      logic [DEPTH-1:0]  vld_q;

      // Flush wins over shift so the byte arriving with the flush is discarded too.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          vld_q <= '0;
        end else if (flush) begin
          vld_q <= '0;
        end else if (shift) begin
          vld_q[0] <= 1'b1;
          for (int i = 1; i < DEPTH; i++) vld_q[i] <= vld_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (shift) begin
          data_q[0] <= din;
          for (int i = 1; i < DEPTH; i++) data_q[i] <= data_q[i-1];
        end
      end

      assign head_valid = vld_q[DEPTH-1];
      assign head_data  = data_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/eth_rx_fcs_check.sv
// RX FCS checker: CRC-32 over each frame incl. FCS, residue check, length/PHY-error status.
// Macro ETH_RX_FCS_STRIP_EN strips the FCS via a 4-byte hold-back; otherwise every byte is forwarded.
module eth_rx_fcs_check
  import eth_pkg::*;
#(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int CNT_WIDTH     = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  input  logic                 in_last,
  input  logic                 in_error,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  output logic                 out_last,
  output logic                 stat_valid,
  output logic                 stat_fcs_ok,
  output logic                 stat_len_err,
  output logic                 stat_phy_err,
  output logic [CNT_WIDTH-1:0] stat_len
);

`ifdef ETH_RX_FCS_STRIP_EN
  localparam int HOLD_DEPTH = FCS_LEN;
`else
  localparam int HOLD_DEPTH = 0;
`endif

  rx_fcs_state_e        state_q, state_d;
  logic [31:0]          crc_q, crc_base, crc_next;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_base, cnt_next;
  logic                 phy_q, phy_next;
  logic                 first, frame_end, head_valid, pop;
  logic [7:0]           head_data;

  // First byte of a frame starts from fresh accumulators, never the stale ones.
  assign first     = (state_q == IDLE);
  assign frame_end = in_valid && in_last;
  assign crc_base  = first ? CRC_INIT : crc_q;
  assign crc_next  = crc32_byte_update(crc_base, in_data);
  assign cnt_base  = first ? '0 : cnt_q;
  assign cnt_next  = (cnt_base == '1) ? cnt_base : cnt_base + CNT_WIDTH'(1);
  assign phy_next  = (first ? 1'b0 : phy_q) | in_error;
  assign pop       = in_valid && head_valid;

  eth_rx_holdback #(
    .DEPTH (HOLD_DEPTH),
    .DATA_W(8)
  ) u_holdback (
    .clk       (clk),
    .reset     (reset),
    .shift     (in_valid),
    .flush     (frame_end),
    .din       (in_data),
    .head_valid(head_valid),
    .head_data (head_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid && !in_last) state_d = FRAME;
      FRAME:   if (frame_end)            state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_q        <= CRC_INIT;
      cnt_q        <= '0;
      phy_q        <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
      stat_valid   <= 1'b0;
      stat_fcs_ok  <= 1'b0;
      stat_len_err <= 1'b0;
      stat_phy_err <= 1'b0;
      stat_len     <= '0;
    end else begin
      out_valid  <= pop;
      out_last   <= pop && in_last;
      stat_valid <= frame_end;
      if (pop) out_data <= head_data;
      if (in_valid) begin
        crc_q <= crc_next;
        cnt_q <= cnt_next;
        phy_q <= phy_next;
      end
      if (frame_end) begin
        stat_fcs_ok  <= (crc_next == CRC_RESIDUE);
        stat_len_err <= (cnt_next < CNT_WIDTH'(MIN_FRAME_LEN)) ||
                        (cnt_next > CNT_WIDTH'(MAX_FRAME_LEN));
        stat_phy_err <= phy_next;
        stat_len     <= cnt_next;
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Directed bench for eth_rx_fcs_check; expected FCS comes from a reflected (LSB-first) CRC-32 reference.
module tb_eth_rx_fcs_check;

  localparam int CNT_WIDTH = 14;
`ifdef ETH_RX_FCS_STRIP_EN
  localparam int HOLD = 4;
`else
  localparam int HOLD = 0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid, in_last, in_error;
  logic [7:0]           in_data;
  logic                 out_valid, out_last;
  logic [7:0]           out_data;
  logic                 stat_valid, stat_fcs_ok, stat_len_err, stat_phy_err;
  logic [CNT_WIDTH-1:0] stat_len;

  eth_rx_fcs_check #(
    .MIN_FRAME_LEN(64),
    .MAX_FRAME_LEN(1518),
    .CNT_WIDTH    (CNT_WIDTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_error    (in_error),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .stat_valid  (stat_valid),
    .stat_fcs_ok (stat_fcs_ok),
    .stat_len_err(stat_len_err),
    .stat_phy_err(stat_phy_err),
    .stat_len    (stat_len)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Stimulus bookkeeping and monitor logs
  logic [7:0] cur[$];
  logic [7:0] sent_b[$];
  int         frame_end_q[$];
  int         exp_ok[$], exp_lerr[$], exp_perr[$], exp_len[$];
  int         in_cyc[$];
  logic [7:0] out_d[$];
  int         out_c[$];
  bit         out_l[$];
  int         st_c[$], st_len[$];
  bit         st_ok[$], st_le[$], st_pe[$];
  int         ncyc = 0;

  always @(negedge clk) begin
    ncyc++;
    if (!reset && in_valid) in_cyc.push_back(ncyc);
    if (out_valid) begin
      out_d.push_back(out_data);
      out_c.push_back(ncyc);
      out_l.push_back(out_last);
    end
    if (stat_valid) begin
      st_c.push_back(ncyc);
      st_ok.push_back(stat_fcs_ok);
      st_le.push_back(stat_len_err);
      st_pe.push_back(stat_phy_err);
      st_len.push_back(int'(stat_len));
    end
  end

  task automatic clear_logs();
    sent_b.delete(); frame_end_q.delete();
    exp_ok.delete(); exp_lerr.delete(); exp_perr.delete(); exp_len.delete();
    in_cyc.delete(); out_d.delete(); out_c.delete(); out_l.delete();
    st_c.delete(); st_len.delete(); st_ok.delete(); st_le.delete(); st_pe.delete();
  endtask

  function automatic logic [31:0] ref_crc(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, cur[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic int ref_ok();
    return (ref_crc(cur.size()) == 32'h2144DF1C) ? 1 : 0;
  endfunction

  task automatic make(input int n, input int mode);
    logic [31:0] c;
    cur.delete();
    for (int i = 0; i < n; i++)
      cur.push_back(mode == 0 ? 8'h00 : (mode == 1 ? 8'(i) : (8'hA5 ^ 8'(i))));
    c = ref_crc(n);
    cur.push_back(c[7:0]); cur.push_back(c[15:8]); cur.push_back(c[23:16]); cur.push_back(c[31:24]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0; in_error = 1'b0;
    end
  endtask

  task automatic send(input int gaps, input int err_idx, input int ok, input int lerr,
                      input int perr, input int len);
    for (int i = 0; i < cur.size(); i++) begin
      if (gaps != 0 && i > 0) idle(int'($urandom_range(0, 2)));
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = cur[i];
      in_last  = (i == cur.size() - 1);
      in_error = (i == err_idx);
      sent_b.push_back(cur[i]);
    end
    frame_end_q.push_back(sent_b.size() - 1);
    exp_ok.push_back(ok); exp_lerr.push_back(lerr); exp_perr.push_back(perr); exp_len.push_back(len);
  endtask

  task automatic check_all(input string tag);
    int fs, k, len, nout, fe;
    fs = 0;
    k  = 0;
    chk({tag, "_nstat"}, st_c.size(), frame_end_q.size());
    for (int f = 0; f < frame_end_q.size(); f++) begin
      fe   = frame_end_q[f];
      len  = fe - fs + 1;
      nout = (len > HOLD) ? len - HOLD : 0;
      for (int j = 0; j < nout; j++) begin
        if (k < out_d.size()) begin
          chk($sformatf("%s_f%0d_b%0d_data", tag, f, j), out_d[k], sent_b[fs+j]);
          chk($sformatf("%s_f%0d_b%0d_cyc", tag, f, j), out_c[k], in_cyc[fs+j+HOLD] + 1);
          chk($sformatf("%s_f%0d_b%0d_last", tag, f, j), out_l[k], (j == nout - 1));
        end
        k++;
      end
      if (f < st_c.size()) begin
        chk($sformatf("%s_f%0d_stcyc", tag, f), st_c[f], in_cyc[fe] + 1);
        chk($sformatf("%s_f%0d_ok", tag, f), st_ok[f], exp_ok[f]);
        chk($sformatf("%s_f%0d_lerr", tag, f), st_le[f], exp_lerr[f]);
        chk($sformatf("%s_f%0d_perr", tag, f), st_pe[f], exp_perr[f]);
        chk($sformatf("%s_f%0d_len", tag, f), st_len[f], exp_len[f]);
      end
      fs = fe + 1;
    end
    chk({tag, "_nout"}, out_d.size(), k);
    chk({tag, "_hold_len"}, stat_len, exp_len[exp_len.size()-1]);
    chk({tag, "_hold_ok"}, stat_fcs_ok, exp_ok[exp_ok.size()-1]);
    chk({tag, "_stv_pulse"}, stat_valid, 0);
    clear_logs();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int nl;
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_error = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_stat_valid", stat_valid, 0);
    chk("rst_fcs_ok", stat_fcs_ok, 0);
    chk("rst_len_err", stat_len_err, 0);
    chk("rst_phy_err", stat_phy_err, 0);
    chk("rst_stat_len", stat_len, 0);
    reset = 1'b0;
    idle(2);
    clear_logs();

    // "123456789" followed by its FCS 0xCBF43926, LSB first
    cur = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h26, 8'h39, 8'hF4, 8'hCB};
    send(0, -1, 1, 1, 0, 13);
    idle(3);
    check_all("crc9");

    cur[3] = 8'h35;
    send(0, -1, 0, 1, 0, 13);
    idle(3);
    check_all("crc9_bad");

    make(60, 0);
    send(1, -1, 1, 0, 0, 64);
    idle(3);
    check_all("zeros_gaps");

    // Errored frame, then two good frames, all back-to-back
    make(60, 1);
    send(0, 10, 1, 0, 1, 64);
    make(60, 2);
    send(0, -1, 1, 0, 0, 64);
    make(70, 1);
    send(0, -1, 1, 0, 0, 74);
    idle(3);
    check_all("b2b");

    cur = '{8'h01, 8'h02, 8'h03};
    send(0, -1, ref_ok(), 1, 0, 3);
    idle(3);
    check_all("len3");

    make(59, 1);
    send(0, -1, 1, 1, 0, 63);
    idle(2);
    check_all("len63");

    make(1514, 2);
    send(0, -1, 1, 0, 0, 1518);
    idle(2);
    check_all("len1518");

    make(1515, 1);
    send(0, -1, 1, 1, 0, 1519);
    idle(2);
    check_all("len1519");

    // Abort a frame with reset, then a clean frame
    make(60, 2);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = cur[i]; in_last = 1'b0; in_error = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_rst_out_valid", out_valid, 0);
    chk("abort_rst_stat_valid", stat_valid, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);
    nl = 0;
    foreach (out_l[i]) nl += int'(out_l[i]);
    chk("abort_out_last", nl, 0);
    chk("abort_nstat", st_c.size(), 0);
    clear_logs();
    make(60, 1);
    send(0, -1, 1, 0, 0, 64);
    idle(3);
    check_all("after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
